// File: rtl/vram_reader_if.sv
// Byte-wide read port between vram_reader and the data RAM's second read port.
interface vram_reader_if;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vram_reader.sv
// Copies a NUM_BYTES window of data RAM into a shadow buffer on each frame_start, then commits it atomically to the display buffer.
// frame_done lands NUM_BYTES+READ_LATENCY cycles after the first read; no backpressure: frame_start while busy is dropped and flagged as overrun.
module vram_reader #(
  parameter logic [7:0] BASE_ADDR    = 8'h00,
  parameter int         NUM_BYTES    = 16,
  parameter int         READ_LATENCY = 1,
  localparam int        IW           = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  vram_reader_if.master ram,
  input  logic [IW-1:0] disp_idx,
  output logic [7:0]    disp_byte,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_t;

  localparam logic [8:0]  NUM_CNT  = 9'(NUM_BYTES);
  localparam logic [8:0]  LAST_CNT = 9'(NUM_BYTES - 1);
  localparam logic [IW:0] NUM_LIM  = (IW+1)'(NUM_BYTES);

  state_t                  state;
  logic [8:0]              issue_cnt;
  logic [8:0]              cap_cnt;
  logic [IW-1:0]           req_idx;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [IW-1:0]           pipe_idx [READ_LATENCY];
  logic [7:0]              shadow   [NUM_BYTES];
  logic [7:0]              display  [NUM_BYTES];
  logic                    cap_vld;
  logic [IW-1:0]           cap_idx;

  assign cap_vld = pipe_vld[READ_LATENCY-1];
  assign cap_idx = pipe_idx[READ_LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      cap_cnt     <= '0;
      req_idx     <= '0;
      ram.rd_en   <= 1'b0;
      ram.rd_addr <= 8'h00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= frame_start && (state != IDLE);
      if (cap_vld) cap_cnt <= cap_cnt + 9'd1;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            ram.rd_en   <= 1'b1;
            ram.rd_addr <= BASE_ADDR;
            req_idx     <= '0;
            issue_cnt   <= 9'd1;
            cap_cnt     <= '0;
          end
        end
        FETCH: begin
          if (issue_cnt == NUM_CNT) begin
            ram.rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            ram.rd_en   <= 1'b1;
            ram.rd_addr <= BASE_ADDR + issue_cnt[7:0];
            req_idx     <= issue_cnt[IW-1:0];
            issue_cnt   <= issue_cnt + 9'd1;
          end
        end
        DRAIN: begin
          // Move on in the same edge that lands the final byte, so COMMIT sees a complete shadow.
          if (cap_vld && cap_cnt == LAST_CNT) begin
            state      <= COMMIT;
            frame_done <= 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 0 captures the request as the RAM samples it; the last stage lines up with rd_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipe_idx[k] <= '0;
    end else begin
      pipe_vld[0] <= ram.rd_en;
      pipe_idx[0] <= req_idx;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_idx[k] <= pipe_idx[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        shadow[i]  <= 8'h00;
        display[i] <= 8'h00;
      end
    end else begin
      if (cap_vld) shadow[cap_idx] <= ram.rd_data;
      if (state == COMMIT) begin
        for (int i = 0; i < NUM_BYTES; i++) display[i] <= shadow[i];
      end
    end
  end

  always_comb begin
    disp_byte = 8'h00;
    if ({1'b0, disp_idx} < NUM_LIM) disp_byte = display[disp_idx];
  end
endmodule

// File: tb/tb_vram_reader.sv
// Directed bench for vram_reader: default instance (base 00, latency 1) and a wrapping instance (base F8, latency 3).
module tb_vram_reader;
  logic       clk;
  logic       rst;
  logic       fs0, fs1;
  logic [3:0] disp_idx0, disp_idx1;
  logic [7:0] disp0, disp1;
  logic       busy0, busy1, fd0, fd1, ovr0, ovr1;

  vram_reader_if if0 ();
  vram_reader_if if1 ();

  vram_reader u0 (
    .clk(clk), .rst(rst), .frame_start(fs0), .ram(if0),
    .disp_idx(disp_idx0), .disp_byte(disp0),
    .busy(busy0), .frame_done(fd0), .overrun(ovr0)
  );

  vram_reader #(.BASE_ADDR(8'hF8), .NUM_BYTES(16), .READ_LATENCY(3)) u1 (
    .clk(clk), .rst(rst), .frame_start(fs1), .ram(if1),
    .disp_idx(disp_idx1), .disp_byte(disp1),
    .busy(busy1), .frame_done(fd1), .overrun(ovr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: latency 1 for u0, latency 3 for u1.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] q0, q1a, q1b, q1c;
  always @(posedge clk) begin
    if (if0.rd_en) q0 <= mem0[if0.rd_addr];
    if (if1.rd_en) q1a <= mem1[if1.rd_addr];
    q1b <= q1a;
    q1c <= q1b;
  end
  assign if0.rd_data = q0;
  assign if1.rd_data = q1c;

  bit sel;
  wire       m_rd_en   = sel ? if1.rd_en   : if0.rd_en;
  wire [7:0] m_rd_addr = sel ? if1.rd_addr : if0.rd_addr;
  wire       m_done    = sel ? fd1   : fd0;
  wire       m_ovr     = sel ? ovr1  : ovr0;
  wire       m_busy    = sel ? busy1 : busy0;
  wire [7:0] m_disp    = sel ? disp1 : disp0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse frame_start on one instance, watch 30 cycles, probe display index 3 throughout.
  task automatic fetch(input bit s, input int extra_at, input logic [7:0] base, input int exp_done,
                       input logic [7:0] old3, input logic [7:0] new3);
    int nreads, ndone, done_cyc, novr;
    logic [7:0] exp3, ea;
    sel = s;
    disp_idx0 = 4'd3;
    disp_idx1 = 4'd3;
    nreads = 0; ndone = 0; done_cyc = 0; novr = 0;
    if (s) fs1 = 1'b1; else fs0 = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      fs0 = 1'b0;
      fs1 = 1'b0;
      if (cyc == extra_at) begin
        if (s) fs1 = 1'b1; else fs0 = 1'b1;
      end
      if (m_rd_en) begin
        ea = base + 8'(cyc - 1);
        check("rd_addr", m_rd_addr, ea);
        check("read_in_window", cyc <= 16, 1);
        nreads++;
      end
      if (m_done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (m_ovr) novr++;
      exp3 = (done_cyc != 0 && cyc > done_cyc) ? new3 : old3;
      check("disp_idx3", m_disp, exp3);
      check("busy", m_busy, cyc <= exp_done);
    end
    check("read_count", nreads, 16);
    check("done_cycle", done_cyc, exp_done);
    check("done_count", ndone, 1);
    check("overrun_count", novr, (extra_at != 0) ? 1 : 0);
  endtask

  typedef struct {
    bit         s;
    logic [3:0] idx;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int nd;
    tbl[0] = '{1'b0, 4'd0,  8'h40};
    tbl[1] = '{1'b0, 4'd5,  8'h45};
    tbl[2] = '{1'b0, 4'd9,  8'h49};
    tbl[3] = '{1'b0, 4'd15, 8'h4F};
    tbl[4] = '{1'b1, 4'd0,  8'hA2};
    tbl[5] = '{1'b1, 4'd7,  8'hA5};
    tbl[6] = '{1'b1, 4'd8,  8'h5A};
    tbl[7] = '{1'b1, 4'd15, 8'h5D};

    for (int i = 0; i < 256; i++) begin
      mem0[i] = (i < 16) ? 8'(i + 8'h40) : 8'h00;
      mem1[i] = 8'(i) ^ 8'h5A;
    end

    rst = 1'b0;
    fs0 = 1'b0;
    fs1 = 1'b0;
    sel = 1'b0;
    disp_idx0 = 4'd0;
    disp_idx1 = 4'd0;

    repeat (3) @(negedge clk);
    check("rst_busy0", busy0, 0);
    check("rst_rd_en0", if0.rd_en, 0);
    check("rst_rd_en1", if1.rd_en, 0);
    check("rst_rd_addr0", if0.rd_addr, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy0", busy0, 0);
    check("idle_busy1", busy1, 0);
    for (int i = 0; i < 16; i++) begin
      disp_idx0 = 4'(i);
      #1;
      check("idle_disp", disp0, 8'h00);
    end
    @(negedge clk);

    fetch(1'b0, 0, 8'h00, 18, 8'h00, 8'h43);
    fetch(1'b1, 0, 8'hF8, 20, 8'h00, 8'hA1);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].s) disp_idx1 = tbl[i].idx; else disp_idx0 = tbl[i].idx;
      sel = tbl[i].s;
      #1;
      check("table_disp", m_disp, tbl[i].exp);
    end
    @(negedge clk);

    mem0[3] = 8'hAA;
    fetch(1'b0, 0, 8'h00, 18, 8'h43, 8'hAA);
    fetch(1'b0, 4, 8'h00, 18, 8'hAA, 8'hAA);

    // Reset asserted while the 7th read is on the bus.
    sel = 1'b0;
    disp_idx0 = 4'd3;
    fs0 = 1'b1;
    @(negedge clk);
    fs0 = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_rd_en", if0.rd_en, 1);
    check("mid_rd_addr", if0.rd_addr, 8'h06);
    rst = 1'b0;
    #1;
    check("arst_rd_en", if0.rd_en, 0);
    check("arst_rd_addr", if0.rd_addr, 8'h00);
    check("arst_busy", busy0, 0);
    check("arst_disp", disp0, 8'h00);
    nd = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fd0) nd++;
    end
    check("no_partial_commit", nd, 0);
    check("post_rst_disp", disp0, 8'h00);

    fetch(1'b0, 0, 8'h00, 18, 8'h00, 8'hAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
